// File: rtl/tick_uart_tx_if.sv
// Word handshake between a producer and the tick-driven UART transmitter.
// The master drives data/valid; the slave returns ready.
interface tick_uart_tx_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/tick_uart_tx.sv
// Serial transmitter paced by an external one-cycle bit-rate tick.
// Frame: start, W data bits LSB first, optional parity, STOP stop bits.
module tick_uart_tx #(
  parameter int W      = 8,
  parameter int PARITY = 0,
  parameter int STOP   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  tick_uart_tx_if.slave        s,
  output logic                 tx,
  output logic                 busy
);

  generate
    if (W < 5 || W > 9) begin : g_bad_w
      $error("tick_uart_tx: W must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("tick_uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP < 1 || STOP > 2) begin : g_bad_stop
      $error("tick_uart_tx: STOP must be 1 or 2");
    end
  endgenerate

  localparam int   BW      = $clog2(W);
  localparam logic [BW-1:0] LASTBIT = BW'(W - 1);
  localparam logic LASTSTOP = 1'(STOP - 1);
  localparam logic ODD      = 1'(PARITY == 2);
  localparam logic HASPAR   = 1'(PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t        state, state_nx;
  logic [W-1:0]  shift, shift_nx;
  logic [BW-1:0] bitcnt, bitcnt_nx;
  logic          stopcnt, stopcnt_nx;
  logic          par_q, par_nx;
  logic          tx_q, tx_nx;
  logic          busy_q, busy_nx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      shift   <= '0;
      bitcnt  <= '0;
      stopcnt <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      shift   <= shift_nx;
      bitcnt  <= bitcnt_nx;
      stopcnt <= stopcnt_nx;
      par_q   <= par_nx;
      tx_q    <= tx_nx;
      busy_q  <= busy_nx;
    end
  end

  // Only IDLE reacts without a tick; all line changes land on tick edges.
  always_comb begin
    state_nx   = state;
    shift_nx   = shift;
    bitcnt_nx  = bitcnt;
    stopcnt_nx = stopcnt;
    par_nx     = par_q;
    tx_nx      = tx_q;
    busy_nx    = busy_q;
    unique case (state)
      S_IDLE: begin
        tx_nx = 1'b1;
        if (s.valid) begin
          shift_nx   = s.data;
          par_nx     = (^s.data) ^ ODD;
          bitcnt_nx  = '0;
          stopcnt_nx = 1'b0;
          busy_nx    = 1'b1;
          state_nx   = S_ARMED;
        end
      end
      S_ARMED: begin
        if (tick) begin
          tx_nx    = 1'b0;
          state_nx = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          tx_nx     = shift[0];
          shift_nx  = shift >> 1;
          bitcnt_nx = '0;
          state_nx  = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bitcnt != LASTBIT) begin
            tx_nx     = shift[0];
            shift_nx  = shift >> 1;
            bitcnt_nx = bitcnt + BW'(1);
          end else if (HASPAR) begin
            tx_nx    = par_q;
            state_nx = S_PAR;
          end else begin
            tx_nx      = 1'b1;
            stopcnt_nx = 1'b0;
            state_nx   = S_STOP;
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          tx_nx      = 1'b1;
          stopcnt_nx = 1'b0;
          state_nx   = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          tx_nx = 1'b1;
          if (stopcnt != LASTSTOP) begin
            stopcnt_nx = 1'b1;
          end else begin
            busy_nx  = 1'b0;
            state_nx = S_IDLE;
          end
        end
      end
      default: begin
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

  assign s.ready = (state == S_IDLE);
  assign tx      = tx_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_tick_uart_tx.sv
// Directed bench for tick_uart_tx: four parameterisations share one tick;
// a selector routes valid to one DUT and muxes its outputs back.
module tb_tick_uart_tx;

  logic       clock;
  logic       reset;
  logic       tick;
  logic [8:0] din;
  logic       vin;
  logic [1:0] sel;
  logic       tx0, tx1, tx2, tx3;
  logic       b0, b1, b2, b3;
  logic       tx_m, busy_m, ready_m;
  int         vecs;
  int         errs;

  tick_uart_tx_if #(.W(8)) if0 ();
  tick_uart_tx_if #(.W(8)) if1 ();
  tick_uart_tx_if #(.W(8)) if2 ();
  tick_uart_tx_if #(.W(7)) if3 ();

  assign if0.data  = din[7:0];
  assign if1.data  = din[7:0];
  assign if2.data  = din[7:0];
  assign if3.data  = din[6:0];
  assign if0.valid = vin && (sel == 2'd0);
  assign if1.valid = vin && (sel == 2'd1);
  assign if2.valid = vin && (sel == 2'd2);
  assign if3.valid = vin && (sel == 2'd3);

  tick_uart_tx u0 (
    .clock(clock), .reset(reset), .tick(tick),
    .s(if0.slave), .tx(tx0), .busy(b0)
  );
  tick_uart_tx #(.PARITY(1)) u1 (
    .clock(clock), .reset(reset), .tick(tick),
    .s(if1.slave), .tx(tx1), .busy(b1)
  );
  tick_uart_tx #(.PARITY(2)) u2 (
    .clock(clock), .reset(reset), .tick(tick),
    .s(if2.slave), .tx(tx2), .busy(b2)
  );
  tick_uart_tx #(.W(7), .STOP(2)) u3 (
    .clock(clock), .reset(reset), .tick(tick),
    .s(if3.slave), .tx(tx3), .busy(b3)
  );

  always_comb begin
    tx_m    = tx0;
    busy_m  = b0;
    ready_m = if0.ready;
    case (sel)
      2'd1: begin tx_m = tx1; busy_m = b1; ready_m = if1.ready; end
      2'd2: begin tx_m = tx2; busy_m = b2; ready_m = if2.ready; end
      2'd3: begin tx_m = tx3; busy_m = b3; ready_m = if3.ready; end
      default: ;
    endcase
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clock);
    #1;
  endtask

  // Handshake, then one compare per tick period against exp[i]; tx must
  // hold between ticks; one more period must end the frame.
  task automatic send(input logic [8:0] d, input logic [15:0] exp,
                      input int n, input int per, input logic hs_tick,
                      input string nm);
    logic prev;
    din = d;
    vin = 1'b1;
    cyc(hs_tick);
    vin = 1'b0;
    vecs++;
    if (ready_m !== 1'b0 || busy_m !== 1'b1 || tx_m !== 1'b1) begin
      errs++;
      $display("FAIL %s handshake: ready=%b busy=%b tx=%b need 0 1 1",
               nm, ready_m, busy_m, tx_m);
    end
    prev = 1'b1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < per - 1; k++) begin
        cyc(1'b0);
        vecs++;
        if (tx_m !== prev) begin
          errs++;
          $display("FAIL %s hold bit%0d: tx=%b need %b", nm, i, tx_m, prev);
        end
      end
      cyc(1'b1);
      vecs++;
      if (tx_m !== exp[i] || ready_m !== 1'b0 || busy_m !== 1'b1) begin
        errs++;
        $display("FAIL %s bit%0d: tx=%b ready=%b busy=%b need tx=%b 0 1",
                 nm, i, tx_m, ready_m, busy_m, exp[i]);
      end
      prev = exp[i];
    end
    for (int k = 0; k < per - 1; k++) cyc(1'b0);
    cyc(1'b1);
    vecs++;
    if (busy_m !== 1'b0 || ready_m !== 1'b1 || tx_m !== 1'b1) begin
      errs++;
      $display("FAIL %s end: busy=%b ready=%b tx=%b need 0 1 1",
               nm, busy_m, ready_m, tx_m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vin   = 1'b1;
    din   = 9'h0A5;
    cyc(1'b1);
    cyc(1'b0);
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      #1;
      vecs++;
      if (tx_m !== 1'b1 || busy_m !== 1'b0 || ready_m !== 1'b1) begin
        errs++;
        $display("FAIL reset dut%0d: tx=%b busy=%b ready=%b need 1 0 1",
                 k, tx_m, busy_m, ready_m);
      end
    end
    vin   = 1'b0;
    sel   = 2'd0;
    reset = 1'b0;
    cyc(1'b0);
  endtask

  task automatic test_default();
    sel = 2'd0;
    send(9'h055, 16'b1010101010, 10, 4, 1'b0, "default_55");
  endtask

  task automatic test_parity();
    sel = 2'd1;
    send(9'h007, 16'b11000001110, 11, 4, 1'b0, "even_07");
    sel = 2'd2;
    send(9'h007, 16'b10000001110, 11, 4, 1'b0, "odd_07");
  endtask

  task automatic test_stop2();
    sel = 2'd3;
    send(9'h07F, 16'b1111111110, 10, 4, 1'b0, "w7_stop2_7f");
  endtask

  task automatic test_tick_handshake();
    sel = 2'd0;
    vin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1);
      vecs++;
      if (tx_m !== 1'b1 || ready_m !== 1'b1) begin
        errs++;
        $display("FAIL idle_tick%0d: tx=%b ready=%b need 1 1",
                 k, tx_m, ready_m);
      end
      cyc(1'b0);
    end
    send(9'h0C3, 16'b1110000110, 10, 4, 1'b1, "hs_on_tick_c3");
  endtask

  task automatic test_period1();
    sel = 2'd0;
    send(9'h02D, 16'b1001011010, 10, 1, 1'b1, "period1_2d");
  endtask

  task automatic test_reset_mid_frame();
    sel = 2'd0;
    din = 9'h0A5;
    vin = 1'b1;
    cyc(1'b0);
    vin = 1'b0;
    for (int p = 0; p < 3; p++) begin
      cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
    end
    vecs++;
    if (tx_m !== 1'b0 || busy_m !== 1'b1) begin
      errs++;
      $display("FAIL midframe_pre: tx=%b busy=%b need 0 1", tx_m, busy_m);
    end
    reset = 1'b1;
    #1;
    vecs++;
    if (tx_m !== 1'b1 || busy_m !== 1'b0 || ready_m !== 1'b1) begin
      errs++;
      $display("FAIL async_reset: tx=%b busy=%b ready=%b need 1 0 1",
               tx_m, busy_m, ready_m);
    end
    vin = 1'b1;
    cyc(1'b1);
    cyc(1'b0);
    vecs++;
    if (busy_m !== 1'b0 || tx_m !== 1'b1) begin
      errs++;
      $display("FAIL hs_in_reset: busy=%b tx=%b need 0 1", busy_m, tx_m);
    end
    vin   = 1'b0;
    reset = 1'b0;
    cyc(1'b0);
    send(9'h0A5, 16'b1101001010, 10, 4, 1'b0, "after_reset_a5");
  endtask

  // valid stays high while data changes each clock; a line receiver
  // rebuilds three W=7 frames and matches them to the handshake words.
  task automatic test_back_to_back();
    logic [6:0] hs_q[$];
    logic [6:0] acc;
    int rx, nb, ns, got;
    logic t;
    sel = 2'd3;
    vin = 1'b1;
    rx  = 0;
    nb  = 0;
    ns  = 0;
    got = 0;
    acc = '0;
    for (int c = 0; c < 400 && got < 3; c++) begin
      din = 9'((c * 29 + 5) % 128);
      t   = (c % 3 == 2);
      if (ready_m === 1'b1) hs_q.push_back(din[6:0]);
      cyc(t);
      if (t) begin
        case (rx)
          0: if (tx_m === 1'b0) begin rx = 1; nb = 0; end
          1: begin
            acc[nb] = tx_m;
            nb++;
            if (nb == 7) begin rx = 2; ns = 0; end
          end
          2: begin
            vecs++;
            if (tx_m !== 1'b1) begin
              errs++;
              $display("FAIL b2b stop%0d frame%0d: tx=%b need 1",
                       ns, got, tx_m);
            end
            ns++;
            if (ns == 2) begin
              vecs++;
              if (hs_q.size() <= got || acc !== hs_q[got]) begin
                errs++;
                $display("FAIL b2b word%0d: got %h need %h",
                         got, acc, hs_q.size() > got ? hs_q[got] : 7'h0);
              end
              got++;
              rx = 3;
            end
          end
          default: begin
            vecs++;
            if (tx_m !== 1'b1) begin
              errs++;
              $display("FAIL b2b gap frame%0d: tx=%b need 1", got, tx_m);
            end
            rx = 0;
          end
        endcase
      end
    end
    vin = 1'b0;
    vecs++;
    if (got != 3) begin
      errs++;
      $display("FAIL b2b timeout: frames=%0d need 3", got);
    end
  endtask

  initial begin
    vecs  = 0;
    errs  = 0;
    sel   = 2'd0;
    vin   = 1'b0;
    din   = '0;
    tick  = 1'b0;
    reset = 1'b1;
    test_reset();
    test_default();
    test_parity();
    test_stop2();
    test_tick_handshake();
    test_period1();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/tick_uart_tx.md
Name: tick_uart_tx

Overview:
- Serial transmitter clocked by an external one-cycle bit-rate tick, normally the `act` output of the periodic strobe timer. It sits directly downstream of that timer.
- Accepts one parallel word per valid/ready handshake. Serialises it on `tx`: start bit, W data bits LSB first, optional parity, STOP stop bits.
- All line transitions are aligned to tick edges, so the baud rate is set entirely by the strobe period.

Parameters:
- W, 8, data bits per frame; legal range 5..9.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP, 1, stop bits per frame; legal range 1..2.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  bit-rate strobe; one clock wide, at most one per bit time; sampled only on rising clock edges.
- data  input  W  word to send; sampled on handshake.
- valid  input  1  data is valid.
- ready  output  1  block can accept a word; high only in IDLE.
- tx  output  1  serial line, idle high.
- busy  output  1  high from handshake until the frame's final stop bit has completed.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, tx=1, busy=0, ready=1, shift register and counters cleared.
  - No handshake is accepted while reset is high.
  - Reset mid-frame aborts immediately; tx returns to 1 without waiting for the clock.
- States: IDLE, ARMED, START, DATA, PARITY, STOP. Only IDLE responds without tick; every other transition requires tick=1 on that edge.
- tx is registered and changes only on edges where tick=1, except on reset. One bit period therefore spans tick to tick.
- IDLE:
  - ready=1, tx=1.
  - valid&ready on an edge: capture data into the shift register, compute the parity bit, set busy=1, go to ARMED.
  - tick in IDLE is ignored.
  - tick coincident with the handshake does NOT start the frame; the start bit waits for the next tick.
- ARMED: ready=0. On tick: tx<=0, go to START.
- START: on tick: tx<=shift[0], shift right, bitcnt<=0, go to DATA.
- DATA:
  - On tick with bitcnt<W-1: tx<=next bit, bitcnt++.
  - On tick with bitcnt==W-1: if PARITY!=0, tx<=parity and go to PARITY. Otherwise tx<=1, stopcnt<=0, go to STOP.
- Parity bit:
  - even: XOR of all W data bits.
  - odd: inverse of that XOR.
- PARITY: on tick: tx<=1, stopcnt<=0, go to STOP.
- STOP:
  - On tick with stopcnt<STOP-1: stopcnt++, tx stays 1.
  - On tick with stopcnt==STOP-1: go to IDLE, busy<=0, ready=1.
  - The next handshake is accepted on the following edge at the earliest.
- Counter widths:
  - bitcnt: clog2(W) bits; it must never wrap (W=8 needs 3 bits; it stops at 7).
  - stopcnt: 1 bit.
- Frame length: 1+W+(PARITY?1:0)+STOP tick periods measured on tx, plus the ARMED wait.
- ARMED wait: 1 to P clocks after handshake, where P is the tick period.
- Changes to data or valid while not in IDLE have no effect; the captured word is held.
- A tick present on every clock (strobe period 1) is legal. The frame then advances one bit per clock.
- Illegal parameter values are an elaboration error.

Test Plan:
- Reset asserted mid-DATA of word 0xA5: tx=1, busy=0 and ready=1 asynchronously, before the next clock edge. The next handshake sends a complete, clean frame.
- Defaults, tick every 4 clocks, handshake data=0x55:
  - tx on successive tick periods: 0, 1,0,1,0,1,0,1,0, 1.
  - busy drops at the tick ending the stop bit.
  - ready is low for the whole frame.
- PARITY=1, data=0x07: parity bit=1. PARITY=2, data=0x07: parity bit=0. Frame is 11 tick periods in both cases.
- STOP=2, W=7, data=0x7F: the 2 stop bits hold tx=1 for 2 tick periods. The back-to-back second word's start bit is at least 1 tick after the first frame's end; no overlap.
- Handshake on the same edge as a tick: tx stays 1 until the next tick, then goes 0. Tick pulses before the handshake leave tx=1.
- valid held high continuously with data changing every clock: each frame carries exactly the word present on its handshake edge. No word is dropped or duplicated across 3 frames.
